vending_machine_controller: RTL and testbench

- Coin-operated vending controller for a single product priced at 35 cents.
- Accepts nickel, dime and quarter deposit strobes and accumulates credit.
- When credit reaches or exceeds the price, it pulses dispense, reports change, and clears credit.
- Sits between the coin-acceptor front end and the dispense/change actuators.

---
 rtl/vending_pkg.sv | 27 ++
 rtl/coin_edge_detect.sv | 28 ++
 rtl/vending_machine_controller.sv | 68 ++++++
 tb/tb_vending_machine_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared constants, state encoding and coin arithmetic for the vending controller.
package vending_pkg;

    localparam int PRICE       = 35;
    localparam int NICKEL_VAL  = 5;
    localparam int DIME_VAL    = 10;
    localparam int QUARTER_VAL = 25;
    localparam int VW          = 7;

    typedef logic [VW-1:0] credit_t;

    typedef enum logic {
        COLLECT  = 1'b0,
        DISPENSE = 1'b1
    } state_t;

    // Credit contributed by the coins whose rising edges were seen this cycle.
    function automatic credit_t coin_sum(input logic n_edge, input logic d_edge, input logic q_edge);
        credit_t sum;
        sum = '0;
        if (n_edge) sum = sum + credit_t'(NICKEL_VAL);
        if (d_edge) sum = sum + credit_t'(DIME_VAL);
        if (q_edge) sum = sum + credit_t'(QUARTER_VAL);
        return sum;
    endfunction

endpackage

// File: rtl/coin_edge_detect.sv
// Registers the three coin strobes and flags the cycle in which each one rises,
// so a coin held high is counted only once.
module coin_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic nickel,
    input  logic dime,
    input  logic quarter,
    output logic n_edge,
    output logic d_edge,
    output logic q_edge
);

    logic [2:0] coin_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coin_prev <= '0;
        end else begin
            coin_prev <= {quarter, dime, nickel};
        end
    end

    assign n_edge = nickel  & ~coin_prev[0];
    assign d_edge = dime    & ~coin_prev[1];
    assign q_edge = quarter & ~coin_prev[2];

endmodule

// File: rtl/vending_machine_controller.sv
// Single-product (35c) vending controller: accumulates coin credit, pulses dispense
// for one cycle once credit reaches the price and reports the change owed.
module vending_machine_controller
    import vending_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          nickel,
    input  logic          dime,
    input  logic          quarter,
    output logic          dispense,
    output logic [VW-1:0] change_out,
    output logic [VW-1:0] current_value
);

    state_t  state_q, state_d;
    credit_t value_q, value_d;
    credit_t add;
    logic    n_edge, d_edge, q_edge;

    coin_edge_detect u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .nickel  (nickel),
        .dime    (dime),
        .quarter (quarter),
        .n_edge  (n_edge),
        .d_edge  (d_edge),
        .q_edge  (q_edge)
    );

    assign add = coin_sum(n_edge, d_edge, q_edge);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
        end
    end

    // Coins arriving during the dispense cycle open the next transaction.
    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        dispense   = 1'b0;
        change_out = '0;
        case (state_q)
            COLLECT: begin
                value_d = value_q + add;
            end
            DISPENSE: begin
                value_d    = add;
                dispense   = 1'b1;
                change_out = value_q - credit_t'(PRICE);
            end
            default: begin
                value_d = '0;
            end
        endcase
        state_d = (value_d >= credit_t'(PRICE)) ? DISPENSE : COLLECT;
    end

    assign current_value = value_q;

endmodule

// File: tb/tb_vending_machine_controller.sv
// Directed-vector bench for vending_machine_controller with a queue-based scoreboard.
module tb_vending_machine_controller;

    logic       clk;
    logic       rst_n;
    logic       nickel;
    logic       dime;
    logic       quarter;
    logic       dispense;
    logic [6:0] change_out;
    logic [6:0] current_value;

    typedef struct {
        logic [6:0] val;
        logic       disp;
        logic [6:0] chg;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    vending_machine_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .nickel        (nickel),
        .dime          (dime),
        .quarter       (quarter),
        .dispense      (dispense),
        .change_out    (change_out),
        .current_value (current_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic apply(input logic r, input logic n, input logic d, input logic q,
                         input logic [6:0] val, input logic disp, input logic [6:0] chg,
                         input string tag);
        exp_t e;
        @(negedge clk);
        rst_n   = r;
        nickel  = n;
        dime    = d;
        quarter = q;
        @(posedge clk);
        #1;
        e.val  = val;
        e.disp = disp;
        e.chg  = chg;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: compares the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (current_value !== e.val || dispense !== e.disp || change_out !== e.chg) begin
                miscompares++;
                $display("FAIL %s: got value=%0d dispense=%0b change=%0d, expected value=%0d dispense=%0b change=%0d",
                         e.tag, current_value, dispense, change_out, e.val, e.disp, e.chg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        nickel      = 1'b0;
        dime        = 1'b0;
        quarter     = 1'b0;

        // Reset with coins asserted: nothing credited
        apply(0, 1, 1, 1,  0, 0,  0, "reset_all_coins");
        apply(0, 0, 0, 1,  0, 0,  0, "reset_quarter");
        apply(1, 0, 0, 0,  0, 0,  0, "reset_release");

        // Exact amount: dime then quarter
        apply(1, 0, 1, 0, 10, 0,  0, "exact_dime");
        apply(1, 0, 0, 0, 10, 0,  0, "exact_idle");
        apply(1, 0, 0, 1, 35, 1,  0, "exact_dispense");
        apply(1, 0, 0, 0,  0, 0,  0, "exact_cleared");

        // Overpay: quarter, quarter
        apply(1, 0, 0, 1, 25, 0,  0, "over_q1");
        apply(1, 0, 0, 0, 25, 0,  0, "over_idle");
        apply(1, 0, 0, 1, 50, 1, 15, "over_dispense");
        apply(1, 0, 0, 0,  0, 0,  0, "over_cleared");

        // Incremental: nickel, dime, dime, nickel, nickel
        apply(1, 1, 0, 0,  5, 0,  0, "inc_n1");
        apply(1, 0, 0, 0,  5, 0,  0, "inc_idle1");
        apply(1, 0, 1, 0, 15, 0,  0, "inc_d1");
        apply(1, 0, 0, 0, 15, 0,  0, "inc_idle2");
        apply(1, 0, 1, 0, 25, 0,  0, "inc_d2");
        apply(1, 0, 0, 0, 25, 0,  0, "inc_idle3");
        apply(1, 1, 0, 0, 30, 0,  0, "inc_n2");
        apply(1, 0, 0, 0, 30, 0,  0, "inc_idle4");
        apply(1, 1, 0, 0, 35, 1,  0, "inc_dispense");
        apply(1, 0, 0, 0,  0, 0,  0, "inc_cleared");

        // Quarter held for five cycles credits once
        for (int i = 0; i < 5; i++) apply(1, 0, 0, 1, 25, 0, 0, "hold_quarter");
        apply(1, 0, 0, 0, 25, 0,  0, "hold_release");
        apply(1, 0, 1, 0, 35, 1,  0, "hold_dispense");
        apply(1, 0, 0, 0,  0, 0,  0, "hold_cleared");

        // Dime and quarter together from zero
        apply(1, 0, 1, 1, 35, 1,  0, "simul_dispense");
        apply(1, 0, 0, 0,  0, 0,  0, "simul_cleared");

        // Quarter edge during the dispense cycle carries into the next transaction
        apply(1, 0, 0, 1, 25, 0,  0, "carry_q");
        apply(1, 0, 0, 0, 25, 0,  0, "carry_idle");
        apply(1, 0, 1, 0, 35, 1,  0, "carry_dispense");
        apply(1, 0, 0, 1, 25, 0,  0, "carry_new_credit");
        apply(1, 0, 0, 0, 25, 0,  0, "carry_idle2");
        apply(1, 0, 1, 0, 35, 1,  0, "carry_dispense2");
        apply(1, 0, 0, 0,  0, 0,  0, "carry_cleared");

        // Combined nickel+dime crossing: change 5
        apply(1, 0, 0, 1, 25, 0,  0, "nd_q");
        apply(1, 0, 0, 0, 25, 0,  0, "nd_idle");
        apply(1, 1, 1, 0, 40, 1,  5, "nd_dispense");
        apply(1, 0, 0, 0,  0, 0,  0, "nd_cleared");

        // 35 cents arriving during a dispense cycle dispenses back-to-back
        apply(1, 0, 0, 1, 25, 0,  0, "b2b_q");
        apply(1, 0, 0, 0, 25, 0,  0, "b2b_idle");
        apply(1, 1, 0, 0, 30, 0,  0, "b2b_n");
        apply(1, 0, 0, 0, 30, 0,  0, "b2b_idle2");
        apply(1, 1, 0, 0, 35, 1,  0, "b2b_dispense1");
        apply(1, 0, 1, 1, 35, 1,  0, "b2b_dispense2");
        apply(1, 0, 0, 0,  0, 0,  0, "b2b_cleared");

        // Maximum credit 30 + 40 = 70, change 35
        apply(1, 0, 0, 1, 25, 0,  0, "max_q");
        apply(1, 0, 0, 0, 25, 0,  0, "max_idle");
        apply(1, 1, 0, 0, 30, 0,  0, "max_n");
        apply(1, 0, 0, 0, 30, 0,  0, "max_idle2");
        apply(1, 1, 1, 1, 70, 1, 35, "max_dispense");
        apply(1, 0, 0, 0,  0, 0,  0, "max_cleared");

        // Mid-transaction reset discards credit, then a normal purchase
        apply(1, 0, 0, 1, 25, 0,  0, "mid_q");
        apply(1, 0, 0, 0, 25, 0,  0, "mid_idle");
        apply(1, 1, 0, 0, 30, 0,  0, "mid_n");
        apply(1, 0, 0, 0, 30, 0,  0, "mid_idle2");
        apply(0, 0, 0, 0,  0, 0,  0, "mid_reset");
        apply(0, 0, 1, 0,  0, 0,  0, "mid_reset_dime");
        apply(1, 0, 0, 0,  0, 0,  0, "mid_release");
        apply(1, 0, 1, 0, 10, 0,  0, "mid_dime");
        apply(1, 0, 0, 0, 10, 0,  0, "mid_idle3");
        apply(1, 0, 0, 1, 35, 1,  0, "mid_dispense");
        apply(1, 0, 0, 0,  0, 0,  0, "mid_cleared");

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
